fetch_ctrl: RTL
===============

# fetch_ctrl

Control-side counterpart of the instruction fetch unit. It owns the run/done handshake with the test bench, holds the fetch unit at address 0 until a run is requested, and decodes each fetched instruction into the `start`, `Branch`, `Target` and `Halt` controls the fetch unit consumes. A 4-bit branch index selects an 8-bit signed PC offset from a lookup table. A cycle counter bounds runaway programs.

## Interface

**Parameters**
- `CNT_W`, default 16: width of the run-cycle counter.
- `MAX_CYCLES`, default 4096: run-cycle limit before a forced stop. Must be ≥ 1 and < 2^CNT_W.

**Ports** (one clock; reset is asynchronous and active-high)
- `CLK`  in  1  system clock; all state updates on its rising edge.
- `Reset`  in  1  asynchronous, active-high reset.
- `Req`  in  1  run request from the test bench; 4-phase handshake with `Ack`.
- `Instr`  in  9  instruction at the current PC, from the combinational instruction ROM.
- `CondFlag`  in  1  registered zero flag from the datapath, used by BEQZ.
- `start`  out  1  to fetch unit; forces PC to 0.
- `Branch`  out  1  to fetch unit; PC <= PC + `Target`.
- `Target`  out  8  signed PC offset. Equals 0 whenever `Branch` = 0.
- `Halt`  out  1  to fetch unit; freezes PC.
- `Ack`  out  1  run finished.
- `Timeout`  out  1  qualifies `Ack`; the run ended on the cycle limit, not on HALT.
- `CycleCount`  out  `CNT_W`  number of RUN cycles in the current or last run.

## Operation

- Opcode is `Instr[8:5]`:
  - BRA = 4'b1101
  - BEQZ = 4'b1110
  - HALT = 4'b1111
  - all other opcodes are non-control.
- Branch index is `Instr[3:0]`; `Target` = LUT[index] when `Branch` = 1.
- **IDLE** (reset state):
  - Outputs: `start` = 1, `Branch` = 0, `Halt` = 0, `Ack` = 0.
  - `Req` = 1 → RUN. On this transition, `CycleCount` and `Timeout` clear to 0.
- **RUN**:
  - `start` = 0, `Ack` = 0.
  - `Branch` = (op == BRA) | (op == BEQZ & `CondFlag`).
  - `Halt` = (op == HALT).
  - `CycleCount` increments each cycle.
  - op == HALT → DONE with `Timeout` <= 0.
  - Else if `CycleCount` == MAX_CYCLES-1 → DONE with `Timeout` <= 1.
  - `Req` is ignored in RUN.
- **DONE**:
  - Outputs: `Halt` = 1, `Ack` = 1, `start` = 0, `Branch` = 0.
  - `CycleCount` and `Timeout` hold.
  - `Req` = 0 → IDLE.
- `start`, `Branch`, `Halt` and `Target` are combinational from state and `Instr`; `Ack` and `Timeout` are registered.

## Timing

- Reset values, immediate on `Reset` assertion: state = IDLE, `start` = 1, `Branch` = 0, `Target` = 0, `Halt` = 0, `Ack` = 0, `Timeout` = 0, `CycleCount` = 0.
- `Req` rises at edge N → RUN from edge N+1. The instruction at PC 0 is decoded in cycle N+1 and steers the PC update at edge N+2.
- Per-instruction latency is 0 cycles: controls are valid in the same cycle `Instr` is presented, ahead of the fetch unit's next edge.
- HALT fetched in cycle K: `Halt` = 1 in cycle K, so PC does not advance. `Ack` rises after edge K+1. `CycleCount` includes the HALT cycle.
- HALT and the cycle limit in the same cycle: HALT wins and `Timeout` = 0.
- `Ack` stays high until `Req` is sampled low. `Ack` drops one edge later and `start` reasserts.
- `Req` held high through DONE: remain in DONE; a new run needs `Req` to fall and then rise again.
- `Reset` mid-run: IDLE immediately. `start` = 1, so the fetch unit returns PC to 0 on its next edge.
- `Target` arithmetic belongs to the fetch unit: 8-bit two's-complement add, wrapping modulo 256.

## Structure

- Package `fetch_pkg` holds:
  - opcode localparams `OP_BRA`, `OP_BEQZ`, `OP_HALT`;
  - a state enum with IDLE, RUN, DONE;
  - the 16-entry × 8-bit constant `BRANCH_OFFSETS`, written by the assembler flow.
- Sub-module `branch_lut`: purely combinational, with 4-bit index in and 8-bit offset out. It reads `BRANCH_OFFSETS`.
- `fetch_ctrl` contains the FSM, counter and decode only.

## Test plan

- **Reset then idle.** Pulse `Reset`, hold `Req` = 0 for 5 cycles → `start` = 1, `Ack` = 0, `CycleCount` = 0 throughout.
- **Straight-line run.**
  - Stimulus: program of 3 non-control instructions then HALT; `Req` = 1.
  - Required: `Branch` never 1; `Halt` = 1 on the 4th RUN cycle; `Ack` = 1 with `Timeout` = 0 and `CycleCount` = 4.
- **Conditional branch.** BEQZ with index 2 and LUT[2] = 8'hFD (-3):
  - `CondFlag` = 1 → `Branch` = 1, `Target` = 8'hFD.
  - `CondFlag` = 0 → `Branch` = 0, `Target` = 0.
- **Timeout.**
  - Stimulus: `MAX_CYCLES` = 8; BRA with LUT offset 0 at PC 0.
  - Required: DONE after 8 RUN cycles, `Timeout` = 1, `CycleCount` = 8.
- **Handshake.**
  - Stimulus: keep `Req` high after `Ack`.
  - Required: stays in DONE. After `Req` falls, `Ack` falls next edge and `start` = 1. A new rise of `Req` restarts with `CycleCount` cleared.
- **Reset mid-run.** Assert `Reset` during cycle 3 of RUN → `start` = 1 and `Branch` = `Halt` = `Ack` = 0 immediately, before the next edge.

Source files
------------

// File: rtl/fetch_pkg.sv
// Shared definitions for the fetch control block: opcodes, FSM states and the
// branch offset table produced by the assembler flow.
package fetch_pkg;

  localparam logic [3:0] OP_BRA  = 4'b1101;
  localparam logic [3:0] OP_BEQZ = 4'b1110;
  localparam logic [3:0] OP_HALT = 4'b1111;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_e;

  // Signed 8-bit PC offsets, indexed by Instr[3:0].
  localparam logic [7:0] BRANCH_OFFSETS [16] = '{
    8'h00, 8'h01, 8'hFD, 8'h02, 8'h04, 8'hFC, 8'h08, 8'hF8,
    8'h10, 8'hF0, 8'h7F, 8'h80, 8'h03, 8'hFE, 8'h05, 8'hFF
  };

endpackage

// File: rtl/branch_lut.sv
// Combinational lookup of a branch PC offset from its 4-bit index.
module branch_lut
  import fetch_pkg::*;
(
  input  logic [3:0] idx,
  output logic [7:0] offset
);

  always_comb begin
    offset = BRANCH_OFFSETS[idx];
  end

endmodule

// File: rtl/fetch_ctrl.sv
// Run/done handshake, cycle-bounded run FSM and instruction decode driving the
// fetch unit's start/Branch/Target/Halt controls.
module fetch_ctrl
  import fetch_pkg::*;
#(
  parameter int unsigned CNT_W      = 16,
  parameter int unsigned MAX_CYCLES = 4096
) (
  input  logic             CLK,
  input  logic             Reset,
  input  logic             Req,
  input  logic [8:0]       Instr,
  input  logic             CondFlag,
  output logic             start,
  output logic             Branch,
  output logic [7:0]       Target,
  output logic             Halt,
  output logic             Ack,
  output logic             Timeout,
  output logic [CNT_W-1:0] CycleCount
);

  localparam logic [CNT_W-1:0] LAST_CYCLE = CNT_W'(MAX_CYCLES - 1);

  state_e     state_q;
  logic [3:0] op;
  logic       op_halt;
  logic       take_branch;
  logic [7:0] lut_offset;
  logic       unused_instr;

  assign op           = Instr[8:5];
  assign unused_instr = Instr[4];

  branch_lut u_branch_lut (
    .idx    (Instr[3:0]),
    .offset (lut_offset)
  );

  always_comb begin
    op_halt     = (op == OP_HALT);
    take_branch = (op == OP_BRA) || ((op == OP_BEQZ) && CondFlag);
    start       = (state_q == IDLE);
    Branch      = (state_q == RUN) && take_branch;
    Halt        = ((state_q == RUN) && op_halt) || (state_q == DONE);
    Target      = Branch ? lut_offset : 8'h00;
  end

  always_ff @(posedge CLK or posedge Reset) begin
    if (Reset) begin
      state_q    <= IDLE;
      Ack        <= 1'b0;
      Timeout    <= 1'b0;
      CycleCount <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (Req) begin
            state_q    <= RUN;
            CycleCount <= '0;
            Timeout    <= 1'b0;
          end
        end
        RUN: begin
          CycleCount <= CycleCount + CNT_W'(1);
          // HALT takes priority over the cycle limit when both land together.
          if (op_halt) begin
            state_q <= DONE;
            Ack     <= 1'b1;
            Timeout <= 1'b0;
          end else if (CycleCount == LAST_CYCLE) begin
            state_q <= DONE;
            Ack     <= 1'b1;
            Timeout <= 1'b1;
          end
        end
        DONE: begin
          if (!Req) begin
            state_q <= IDLE;
            Ack     <= 1'b0;
          end
        end
        default: begin
          state_q <= IDLE;
          Ack     <= 1'b0;
        end
      endcase
    end
  end

endmodule
